// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if
//   Control/status bundle for the LED pattern engine.
//   Build option: LED_PAT_PWM_EN adds the 4-bit duty (PWM brightness) signal.
//
//   en          host -> engine   1 = run, 0 = pause
//   mode[1:0]   host -> engine   00 rotate-up, 01 rotate-down, 10 bounce, 11 blink
//   speed[1:0]  host -> engine   step period = STEP_CYC >> speed
//   duty[3:0]   host -> engine   PWM brightness (LED_PAT_PWM_EN only)
//   step_pulse  engine -> host   one-cycle strobe on each new pattern
//   led[W-1:0]  engine -> pins   LED drive, active high
//
//   master: the controlling side (switches / host register / testbench)
//   slave : the pattern engine
interface led_pattern_gen_if #(
    parameter int unsigned LED_W = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [1:0]       speed;
`ifdef LED_PAT_PWM_EN
    logic [3:0]       duty;
`endif
    logic             step_pulse;
    logic [LED_W-1:0] led;

`ifdef LED_PAT_PWM_EN
    modport master (output en, mode, speed, duty, input step_pulse, led);
    modport slave  (input en, mode, speed, duty, output step_pulse, led);
`else
    modport master (output en, mode, speed, input step_pulse, led);
    modport slave  (input en, mode, speed, output step_pulse, led);
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Parametrised LED pattern engine. A prescaler derives a step tick from
//   sys_clk; on each tick the pattern advances in rotate-up, rotate-down,
//   bounce or blink mode. A mode change reloads the mode's start pattern.
//   Build option: LED_PAT_PWM_EN adds a 16-level PWM brightness gate on led.
//
//   Parameters
//     LED_W     number of LEDs (2..32)
//     STEP_CYC  base step period in sys_clk cycles (>= 8)
//   Ports
//     sys_clk    system clock
//     sys_rst_n  asynchronous active-low reset
//     bus        led_pattern_gen_if.slave: en, mode, speed, [duty] in;
//                step_pulse, led out
module led_pattern_gen #(
    parameter int unsigned LED_W    = 4,
    parameter int unsigned STEP_CYC = 10_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    led_pattern_gen_if.slave bus
);

    localparam int unsigned CW = $clog2(STEP_CYC);
    localparam logic [LED_W-1:0] ONE_HOT = {{(LED_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    mode_e            w_mode;
    mode_e            r_mode_q;
    logic [CW-1:0]    r_cnt;
    logic [LED_W-1:0] r_pat;
    logic             r_dir;
    logic             r_step_pulse;

    logic [31:0]      w_period;
    logic             w_tick;
    logic             w_reload;
    logic [LED_W-1:0] w_init_pat;
    logic [LED_W-1:0] w_next_pat;
    logic             w_next_dir;

    assign w_mode   = mode_e'(bus.mode);
    assign w_period = STEP_CYC >> bus.speed;

    // >= rather than == so a speed change that shrinks the period below the
    // current count ticks on the next cycle instead of wrapping the counter.
    assign w_tick   = bus.en && (32'(r_cnt) >= (w_period - 32'd1));
    assign w_reload = (w_mode != r_mode_q);

    assign w_init_pat = (w_mode == MODE_BLINK) ? '1 : ONE_HOT;

    // Next pattern on a tick. r_mode_q equals the live mode whenever no
    // reload is pending, and a reload overrides this result anyway.
    always_comb begin
        w_next_pat = r_pat;
        w_next_dir = r_dir;
        unique case (r_mode_q)
            MODE_UP:   w_next_pat = {r_pat[LED_W-2:0], r_pat[LED_W-1]};
            MODE_DOWN: w_next_pat = {r_pat[0], r_pat[LED_W-1:1]};
            MODE_BOUNCE: begin
                // Turn around on the step after reaching an end, so each end
                // LED is lit for exactly one step.
                if (r_dir && r_pat[LED_W-1]) begin
                    w_next_dir = 1'b0;
                    w_next_pat = r_pat >> 1;
                end else if (!r_dir && r_pat[0]) begin
                    w_next_dir = 1'b1;
                    w_next_pat = r_pat << 1;
                end else if (r_dir) begin
                    w_next_pat = r_pat << 1;
                end else begin
                    w_next_pat = r_pat >> 1;
                end
            end
            MODE_BLINK: w_next_pat = ~r_pat;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode_q     <= MODE_UP;
            r_cnt        <= '0;
            r_pat        <= ONE_HOT;
            r_dir        <= 1'b1;
            r_step_pulse <= 1'b0;
        end else begin
            r_mode_q     <= w_mode;
            r_step_pulse <= w_reload || w_tick;
            if (w_reload) begin
                // Reload wins over a coincident tick and ignores en.
                r_pat <= w_init_pat;
                r_dir <= 1'b1;
                r_cnt <= '0;
            end else if (w_tick) begin
                r_pat <= w_next_pat;
                r_dir <= w_next_dir;
                r_cnt <= '0;
            end else if (bus.en) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.step_pulse = r_step_pulse;

`ifdef LED_PAT_PWM_EN
    logic [3:0] r_pwm_cnt;

    // Free-running, keeps counting while paused.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign bus.led = r_pat & {LED_W{r_pwm_cnt <= bus.duty}};
`else
    assign bus.led = r_pat;
`endif

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine that drives the board LED bank with selectable animations and run-time speed control. It takes over from the fixed 4-LED one-hot rotator. A prescaler derives a step tick from the 50 MHz system clock, and a pattern register advances on each tick in rotate-up, rotate-down, bounce or blink mode. It sits directly between the board clock/reset pins and the LED pins, with mode, speed and enable driven from switches or a host register.

## Interface
- LED_W, 4: number of LEDs; legal range 2..32.
- STEP_CYC, 10_000_000: base step period in sys_clk cycles, which is 0.2 s at 50 MHz; must be at least 8.
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset. Assertion is asynchronous; release is sampled on sys_clk.
- en  in  1  1 = run; 0 = pause, which freezes the prescaler, the pattern and the direction.
- mode  in  2  00 rotate-up, 01 rotate-down, 10 bounce, 11 blink.
- speed  in  2  step period P = STEP_CYC >> speed (1x, 2x, 4x, 8x faster).
- duty  in  4  PWM brightness. Present only with LED_PAT_PWM_EN.
- step_pulse  out  1  one-cycle strobe, high in the first cycle a new pattern is shown.
- led  out  LED_W  LED drive, active high.

## Operation
- The prescaler `cnt` has width $clog2(STEP_CYC).
  - Tick condition: en=1 and cnt >= P-1. On a tick, cnt <= 0.
  - Otherwise, if en=1, cnt increments.
  - If en=0, cnt holds.
  - Using >= means a speed change that shrinks P below the current cnt fires a tick on the next cycle, never a wrap through 2^width.
- Pattern register `pat` (LED_W bits) on a tick:
  - Rotate-up: pat <= {pat[LED_W-2:0], pat[LED_W-1]}.
  - Rotate-down: pat <= {pat[0], pat[LED_W-1:1]}.
  - Bounce: `dir` 1 = up.
    - If dir=1 and pat[LED_W-1]=1: set dir <= 0 and shift right.
    - If dir=0 and pat[0]=1: set dir <= 1 and shift left.
    - Otherwise shift in the direction of dir.
    - Each end LED is lit for exactly one step. For LED_W=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - Blink: pat <= ~pat. Starts from all ones.
- Mode change:
  - `mode_q` registers mode every cycle.
  - When mode != mode_q, on the next edge:
    - pat reloads to the initial pattern for the new mode: one-hot bit0 for modes 00/01/10, all ones for 11.
    - dir <= 1.
    - cnt <= 0.
    - step_pulse <= 1.
  - A reload takes priority over a simultaneous tick, and applies even when en=0.
- Non-blink modes always hold exactly one set bit; blink alternates between all-ones and all-zeros.
- step_pulse is registered. It is 1 in the cycle after a tick or reload edge and 0 otherwise.

## Timing
- Reset values:
  - pat = one-hot bit0 (led = 0…01)
  - dir = 1
  - cnt = 0
  - mode_q = 00
  - step_pulse = 0
  - pwm_cnt = 0
- If mode != 00 at reset release, a reload occurs on the first edge.
- First step: with en held at 1 from release, pat changes on the P-th rising edge after release. Subsequent steps follow every P cycles.
- led and step_pulse change on the same edge. Latency from tick condition to output is 1 cycle.
- Pause: dropping en stops cnt at its current value. Raising en resumes from that count with no lost or extra step.
- en, mode and speed are synchronous inputs; the external driver debounces and synchronises them.
- Reset mid-pattern returns all state to reset values immediately (asynchronous).

## Configuration
- LED_PAT_PWM_EN defined:
  - Adds the duty port and a 4-bit free-running pwm_cnt (0..15, wraps).
  - led = pat & {LED_W{pwm_cnt <= duty}}.
  - duty=15 gives full on; duty=0 gives 1/16 on-time.
  - PWM runs while paused; step_pulse is unaffected.
- LED_PAT_PWM_EN undefined: no duty port, no pwm_cnt, and led = pat.

## Test plan
- Rotate-up: LED_W=4, STEP_CYC=8, speed=0, mode=00, en=1 from reset.
  - led = 0001 → 0010 at edge 8 after release → 0100 at edge 16 → 1000 at edge 24 → 0001 at edge 32.
  - step_pulse is high exactly one cycle at each change.
- Bounce: mode=10, STEP_CYC=8, speed=1 (P=4).
  - Sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 at 4-cycle spacing.
- Pause: en=0 at cnt=5, held 20 cycles, then en=1.
  - led is unchanged during the pause.
  - The next step occurs 3 cycles after resume (P=8 base, speed=0).
- Mode switch mid-step: at cnt=3 in rotate-up with led=0100, mode → 11.
  - Next edge gives led=1111 and step_pulse=1; cnt=0 after that edge.
  - led=0000 follows 8 cycles later, then 1111.
- Speed shrink: at cnt=6 with speed=0 (P=8), switch to speed=2 (P=2).
  - A tick occurs on the next edge, then steps every 2 cycles.
- Reset: assert sys_rst_n=0 asynchronously mid-cycle with led=1000.
  - led=0001 immediately and step_pulse=0.
  - With LED_PAT_PWM_EN and duty=3: after release, led bit0 is high for 4 of every 16 cycles.
